// File: rtl/rob_queue_if.sv
// Dispatch, writeback and commit bundle for rob_queue.
// With ROB_SKIP_EN defined, the wb_skip / cmt_skip pair is added.
interface rob_queue_if #(
  parameter int DEPTH     = 16,
  parameter int ENQ_WIDTH = 2,
  parameter int WB_PORTS  = 3,
  parameter int CMT_WIDTH = 2,
  parameter int PC_W      = 64,
  parameter int LREG_W    = 5,
  parameter int PREG_W    = 6
) ();
  localparam int IDX_W = $clog2(DEPTH);

  logic [ENQ_WIDTH-1:0]        enq_valid;
  logic                        enq_ready;
  logic [ENQ_WIDTH*PC_W-1:0]   enq_pc;
  logic [ENQ_WIDTH*32-1:0]     enq_instr;
  logic [ENQ_WIDTH*LREG_W-1:0] enq_lrd;
  logic [ENQ_WIDTH*PREG_W-1:0] enq_prd;
  logic [ENQ_WIDTH*PREG_W-1:0] enq_old_prd;
  logic [ENQ_WIDTH*IDX_W-1:0]  enq_idx;
  logic [WB_PORTS-1:0]         wb_valid;
  logic [WB_PORTS*IDX_W-1:0]   wb_idx;
  logic [CMT_WIDTH-1:0]        cmt_valid;
  logic [CMT_WIDTH*PC_W-1:0]   cmt_pc;
  logic [CMT_WIDTH*32-1:0]     cmt_instr;
  logic [CMT_WIDTH*LREG_W-1:0] cmt_lrd;
  logic [CMT_WIDTH*PREG_W-1:0] cmt_prd;
  logic [CMT_WIDTH*PREG_W-1:0] cmt_old_prd;
  logic [IDX_W:0]              count;
  logic                        empty;
  logic                        flush;
`ifdef ROB_SKIP_EN
  logic [WB_PORTS-1:0]         wb_skip;
  logic [CMT_WIDTH-1:0]        cmt_skip;
`endif

  modport master (
    output enq_valid, enq_pc, enq_instr, enq_lrd, enq_prd, enq_old_prd,
    output wb_valid, wb_idx, flush,
`ifdef ROB_SKIP_EN
    output wb_skip,
    input  cmt_skip,
`endif
    input  enq_ready, enq_idx, cmt_valid, cmt_pc, cmt_instr, cmt_lrd,
    input  cmt_prd, cmt_old_prd, count, empty
  );

  modport slave (
    input  enq_valid, enq_pc, enq_instr, enq_lrd, enq_prd, enq_old_prd,
    input  wb_valid, wb_idx, flush,
`ifdef ROB_SKIP_EN
    input  wb_skip,
    output cmt_skip,
`endif
    output enq_ready, enq_idx, cmt_valid, cmt_pc, cmt_instr, cmt_lrd,
    output cmt_prd, cmt_old_prd, count, empty
  );
endinterface

// File: rtl/rob_queue.sv
// In-order reorder buffer: multi-lane dispatch, multi-port writeback, in-order multi-lane commit.
// Optional per-entry skip flag is enabled with `define ROB_SKIP_EN.
module rob_queue #(
  parameter int DEPTH     = 16,
  parameter int ENQ_WIDTH = 2,
  parameter int WB_PORTS  = 3,
  parameter int CMT_WIDTH = 2,
  parameter int PC_W      = 64,
  parameter int LREG_W    = 5,
  parameter int PREG_W    = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  rob_queue_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W-1:0]     count;
  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     complete;
  logic [PC_W-1:0]      pc_mem      [DEPTH];
  logic [31:0]          instr_mem   [DEPTH];
  logic [LREG_W-1:0]    lrd_mem     [DEPTH];
  logic [PREG_W-1:0]    prd_mem     [DEPTH];
  logic [PREG_W-1:0]    old_prd_mem [DEPTH];
`ifdef ROB_SKIP_EN
  logic [DEPTH-1:0]     skip;
`endif

  logic                 full;
  logic                 enq_ok;
  logic [PTR_W:0]       free_slots;
  logic [PTR_W-1:0]     enq_num;
  logic [PTR_W-1:0]     cmt_num;
  logic [IDX_W-1:0]     cmt_slot [CMT_WIDTH];
  logic [CMT_WIDTH-1:0] cmt_ok;

  function automatic logic [PTR_W-1:0] popcount(input logic [31:0] v);
    logic [PTR_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {{IDX_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Admission uses the registered count only; slots retiring this cycle are not credited.
  assign full       = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  assign free_slots = (PTR_W+1)'(DEPTH) - {1'b0, count};
  assign enq_ok     = !full && (free_slots >= (PTR_W+1)'(ENQ_WIDTH));
  assign enq_num    = enq_ok ? popcount(32'(bus.enq_valid)) : '0;
  assign cmt_num    = popcount(32'(cmt_ok));

  assign bus.enq_ready = enq_ok;
  assign bus.cmt_valid = cmt_ok;
  assign bus.count     = count;
  assign bus.empty     = (count == '0);

  // Slot selection: dispatch lane i targets tail+i; commit lanes stop at the first unfinished entry.
  always_comb begin
    logic run;
    run         = 1'b1;
    bus.enq_idx = '0;
    cmt_ok      = '0;
    cmt_slot    = '{default: '0};
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      bus.enq_idx[i*IDX_W +: IDX_W] = tail[IDX_W-1:0] + IDX_W'(i);
    end
    for (int k = 0; k < CMT_WIDTH; k++) begin
      cmt_slot[k] = head[IDX_W-1:0] + IDX_W'(k);
      run         = run & valid[cmt_slot[k]] & complete[cmt_slot[k]];
      cmt_ok[k]   = run;
    end
  end

  // Retired fields come straight from the entry at head+k, whether or not it retires.
  always_comb begin
    bus.cmt_pc      = '0;
    bus.cmt_instr   = '0;
    bus.cmt_lrd     = '0;
    bus.cmt_prd     = '0;
    bus.cmt_old_prd = '0;
`ifdef ROB_SKIP_EN
    bus.cmt_skip    = '0;
`endif
    for (int k = 0; k < CMT_WIDTH; k++) begin
      bus.cmt_pc[k*PC_W +: PC_W]          = pc_mem[cmt_slot[k]];
      bus.cmt_instr[k*32 +: 32]           = instr_mem[cmt_slot[k]];
      bus.cmt_lrd[k*LREG_W +: LREG_W]     = lrd_mem[cmt_slot[k]];
      bus.cmt_prd[k*PREG_W +: PREG_W]     = prd_mem[cmt_slot[k]];
      bus.cmt_old_prd[k*PREG_W +: PREG_W] = old_prd_mem[cmt_slot[k]];
`ifdef ROB_SKIP_EN
      bus.cmt_skip[k]                     = skip[cmt_slot[k]];
`endif
    end
  end

  // Entry state and pointers: flush dominates; otherwise writeback, commit and dispatch act together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      complete <= '0;
`ifdef ROB_SKIP_EN
      skip     <= '0;
`endif
      for (int e = 0; e < DEPTH; e++) begin
        pc_mem[e]      <= '0;
        instr_mem[e]   <= '0;
        lrd_mem[e]     <= '0;
        prd_mem[e]     <= '0;
        old_prd_mem[e] <= '0;
      end
    end else if (bus.flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      complete <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (bus.wb_valid[p] && valid[bus.wb_idx[p*IDX_W +: IDX_W]]) begin
          complete[bus.wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
`ifdef ROB_SKIP_EN
          skip[bus.wb_idx[p*IDX_W +: IDX_W]]     <= bus.wb_skip[p];
`endif
        end
      end
      // A writeback landing on a retiring entry is overridden by the clear below.
      for (int k = 0; k < CMT_WIDTH; k++) begin
        if (cmt_ok[k]) begin
          valid[cmt_slot[k]]    <= 1'b0;
          complete[cmt_slot[k]] <= 1'b0;
        end
      end
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (enq_ok && bus.enq_valid[i]) begin
          valid[bus.enq_idx[i*IDX_W +: IDX_W]]       <= 1'b1;
          complete[bus.enq_idx[i*IDX_W +: IDX_W]]    <= 1'b0;
`ifdef ROB_SKIP_EN
          skip[bus.enq_idx[i*IDX_W +: IDX_W]]        <= 1'b0;
`endif
          pc_mem[bus.enq_idx[i*IDX_W +: IDX_W]]      <= bus.enq_pc[i*PC_W +: PC_W];
          instr_mem[bus.enq_idx[i*IDX_W +: IDX_W]]   <= bus.enq_instr[i*32 +: 32];
          lrd_mem[bus.enq_idx[i*IDX_W +: IDX_W]]     <= bus.enq_lrd[i*LREG_W +: LREG_W];
          prd_mem[bus.enq_idx[i*IDX_W +: IDX_W]]     <= bus.enq_prd[i*PREG_W +: PREG_W];
          old_prd_mem[bus.enq_idx[i*IDX_W +: IDX_W]] <= bus.enq_old_prd[i*PREG_W +: PREG_W];
        end
      end
      head  <= head + cmt_num;
      tail  <= tail + enq_num;
      count <= count + enq_num - cmt_num;
    end
  end
endmodule

// File: tb/tb_rob_queue.sv
// Directed bench for rob_queue with a small in-order reference model for commit order and occupancy.
module tb_rob_queue;
  localparam int DEPTH = 16, EW = 2, WB = 3, CW = 2, PC_W = 64, LREG_W = 5, PREG_W = 6, IDX_W = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_mis   = 0;

  logic        m_valid [DEPTH];
  logic        m_comp  [DEPTH];
  logic        m_skip  [DEPTH];
  logic [63:0] m_pc    [DEPTH];
  int          m_head, m_tail, m_count;

  rob_queue_if #(.DEPTH(DEPTH), .ENQ_WIDTH(EW), .WB_PORTS(WB), .CMT_WIDTH(CW),
                 .PC_W(PC_W), .LREG_W(LREG_W), .PREG_W(PREG_W)) bus ();

  rob_queue #(.DEPTH(DEPTH), .ENQ_WIDTH(EW), .WB_PORTS(WB), .CMT_WIDTH(CW),
              .PC_W(PC_W), .LREG_W(LREG_W), .PREG_W(PREG_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] fields(input logic [63:0] pc);
    return {pc[31:0] ^ 32'hA5A5_0000, pc[6:2], pc[7:2], ~pc[7:2]};
  endfunction

  task automatic model_reset();
    for (int e = 0; e < DEPTH; e++) begin
      m_valid[e] = 1'b0;
      m_comp[e]  = 1'b0;
      m_pc[e]    = 64'd0;
    end
    m_head  = 0;
    m_tail  = 0;
    m_count = 0;
  endtask

  task automatic drive_enq(input int n, input logic [63:0] pc0);
    logic [63:0] p;
    for (int i = 0; i < EW; i++) begin
      p = pc0 + 64'(4 * i);
      bus.enq_valid[i] = (i < n);
      bus.enq_pc[i*PC_W +: PC_W] = p;
      {bus.enq_instr[i*32 +: 32], bus.enq_lrd[i*LREG_W +: LREG_W],
       bus.enq_prd[i*PREG_W +: PREG_W], bus.enq_old_prd[i*PREG_W +: PREG_W]} = fields(p);
    end
  endtask

  task automatic drive_wb(input int port, input int idx);
    bus.wb_valid[port] = 1'b1;
    bus.wb_idx[port*IDX_W +: IDX_W] = IDX_W'(idx % DEPTH);
  endtask

`ifdef ROB_SKIP_EN
  task automatic set_skip(input int port, input logic s);
    bus.wb_skip[port] = s;
  endtask
`endif

  // Check combinational outputs against the model, advance the model as the edge will, then clock.
  task automatic tick();
    logic [CW-1:0]       ec;
    logic [EW*IDX_W-1:0] ei;
    logic                run, er;
    int                  h, nc, ne, wi;
    run = 1'b1; ec = '0; nc = 0; ne = 0;
    for (int k = 0; k < CW; k++) begin
      h = (m_head + k) % DEPTH;
      run = run && m_valid[h] && m_comp[h];
      ec[k] = run;
      if (run) nc++;
    end
    for (int i = 0; i < EW; i++) ei[i*IDX_W +: IDX_W] = IDX_W'((m_tail + i) % DEPTH);
    er = (DEPTH - m_count) >= EW;
    check("cmt_valid", 64'(bus.cmt_valid), 64'(ec));
    check("enq_ready", 64'(bus.enq_ready), 64'(er));
    check("enq_idx", 64'(bus.enq_idx), 64'(ei));
    for (int k = 0; k < CW; k++) begin
      if (ec[k]) begin
        h = (m_head + k) % DEPTH;
        check("cmt_pc", bus.cmt_pc[k*PC_W +: PC_W], m_pc[h]);
        check("cmt_fields", 64'({bus.cmt_instr[k*32 +: 32], bus.cmt_lrd[k*LREG_W +: LREG_W],
              bus.cmt_prd[k*PREG_W +: PREG_W], bus.cmt_old_prd[k*PREG_W +: PREG_W]}), 64'(fields(m_pc[h])));
`ifdef ROB_SKIP_EN
        check("cmt_skip", 64'(bus.cmt_skip[k]), 64'(m_skip[h]));
`endif
      end
    end
    if (bus.flush) begin
      model_reset();
    end else begin
      for (int p = 0; p < WB; p++) begin
        wi = int'(bus.wb_idx[p*IDX_W +: IDX_W]);
        if (bus.wb_valid[p] && m_valid[wi]) begin
          m_comp[wi] = 1'b1;
`ifdef ROB_SKIP_EN
          m_skip[wi] = bus.wb_skip[p];
`endif
        end
      end
      for (int k = 0; k < CW; k++) begin
        if (ec[k]) begin
          m_valid[(m_head + k) % DEPTH] = 1'b0;
          m_comp[(m_head + k) % DEPTH]  = 1'b0;
        end
      end
      m_head = (m_head + nc) % (2 * DEPTH);
      for (int i = 0; i < EW; i++) begin
        if (er && bus.enq_valid[i]) begin
          h = (m_tail + i) % DEPTH;
          m_valid[h] = 1'b1;
          m_comp[h]  = 1'b0;
          m_skip[h]  = 1'b0;
          m_pc[h]    = bus.enq_pc[i*PC_W +: PC_W];
          ne++;
        end
      end
      m_tail  = (m_tail + ne) % (2 * DEPTH);
      m_count = m_count + ne - nc;
    end
    @(posedge clock);
    #1;
    bus.enq_valid = '0;
    bus.wb_valid  = '0;
    bus.flush     = 1'b0;
`ifdef ROB_SKIP_EN
    bus.wb_skip   = '0;
`endif
    check("count", 64'(bus.count), 64'(m_count));
    check("empty", 64'(bus.empty), 64'(m_count == 0));
  endtask

  initial begin
    int prev0, prev1, base;
    bus.enq_valid = '0; bus.enq_pc = '0; bus.enq_instr = '0; bus.enq_lrd = '0;
    bus.enq_prd = '0; bus.enq_old_prd = '0; bus.wb_valid = '0; bus.wb_idx = '0; bus.flush = 1'b0;
`ifdef ROB_SKIP_EN
    bus.wb_skip = '0;
    for (int e = 0; e < DEPTH; e++) m_skip[e] = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    check("rst_cmt_valid", 64'(bus.cmt_valid), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_enq_idx", 64'(bus.enq_idx), 64'h10);
    check("rst_cmt_pc", bus.cmt_pc[63:0], 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Two-lane dispatch, then out-of-order writeback.
    check("idx_lanes", 64'(bus.enq_idx), 64'h10);
    drive_enq(2, 64'h100); tick();
    check("cnt_after_enq", 64'(bus.count), 64'd2);
    check("no_commit_yet", 64'(bus.cmt_valid), 64'd0);
    drive_wb(0, 1); tick();
    check("hold_behind_gap", 64'(bus.cmt_valid), 64'd0);
    drive_wb(2, 0); tick();
    check("cmt_both", 64'(bus.cmt_valid), 64'd3);
    check("cmt_pc0", bus.cmt_pc[63:0], 64'h100);
    check("cmt_pc1", bus.cmt_pc[127:64], 64'h104);
    tick();
    check("drained", 64'(bus.count), 64'd0);

    // Fill to 15, no same-cycle credit for retiring slots.
    for (int j = 0; j < 7; j++) begin drive_enq(2, 64'h200 + 64'(8 * j)); tick(); end
    check("ready_at_14", 64'(bus.enq_ready), 64'd1);
    drive_enq(1, 64'h238); tick();
    check("cnt15", 64'(bus.count), 64'd15);
    check("not_ready_15", 64'(bus.enq_ready), 64'd0);
    drive_enq(2, 64'hDEAD0); tick();
    check("rejected_enq", 64'(bus.count), 64'd15);
    drive_wb(0, 2); drive_wb(1, 3); tick();
    check("no_credit", 64'(bus.enq_ready), 64'd0);
    tick();
    check("cnt13", 64'(bus.count), 64'd13);
    check("ready_after_cmt", 64'(bus.enq_ready), 64'd1);
    for (int j = 0; j < 13; j += 3) begin
      for (int p = 0; p < 3; p++) if (j + p < 13) drive_wb(p, 4 + j + p);
      tick();
    end
    repeat (8) tick();
    check("empty_after_fill", 64'(bus.empty), 64'd1);

    // Forty steady-state rounds, indices wrapping several times.
    prev0 = 0; prev1 = 0;
    for (int r = 0; r < 40; r++) begin
      drive_enq(2, 64'h1000 + 64'(8 * r));
      if (r > 0) begin drive_wb(0, prev0); drive_wb(1, prev1); end
      prev0 = m_tail % DEPTH;
      prev1 = (m_tail + 1) % DEPTH;
      tick();
    end
    drive_wb(0, prev0); drive_wb(1, prev1); tick();
    repeat (3) tick();
    check("empty_after_rounds", 64'(bus.empty), 64'd1);

    // Completely full across a wrap, then drain.
    base = m_head;
    for (int j = 0; j < 8; j++) begin drive_enq(2, 64'h5000 + 64'(8 * j)); tick(); end
    check("full_count", 64'(bus.count), 64'd16);
    check("full_not_ready", 64'(bus.enq_ready), 64'd0);
    check("full_not_empty", 64'(bus.empty), 64'd0);
    for (int j = 0; j < 16; j += 3) begin
      for (int p = 0; p < 3; p++) if (j + p < 16) drive_wb(p, base + j + p);
      tick();
    end
    repeat (8) tick();
    check("empty_after_full", 64'(bus.empty), 64'd1);

    // Reset asserted mid-operation.
    drive_enq(2, 64'h6000); tick();
    drive_wb(0, m_head); tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_count", 64'(bus.count), 64'd0);
    check("midrst_cmt_valid", 64'(bus.cmt_valid), 64'd0);
    check("midrst_enq_idx", 64'(bus.enq_idx), 64'h10);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    drive_enq(2, 64'h7000); tick();

    // Flush with concurrent dispatch and writeback.
    drive_enq(2, 64'h3000); drive_wb(0, 0); drive_wb(1, 1); bus.flush = 1'b1; tick();
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_empty", 64'(bus.empty), 64'd1);
    check("flush_enq_idx", 64'(bus.enq_idx), 64'h10);
    drive_enq(1, 64'h8000); tick();
    tick();
    check("stale_wb", 64'(bus.cmt_valid), 64'd0);
    drive_wb(0, 0); tick();
    tick();

`ifdef ROB_SKIP_EN
    bus.flush = 1'b1; tick();
    drive_enq(2, 64'h9000); tick();
    drive_enq(2, 64'h9008); tick();
    drive_wb(0, 0); drive_wb(1, 1); drive_wb(2, 2); tick();
    drive_wb(0, 3); set_skip(0, 1'b1); tick();
    check("skip_at_commit", 64'(bus.cmt_skip), 64'd2);
    tick();
    bus.flush = 1'b1; tick();
    drive_enq(2, 64'hA000); tick();
    drive_enq(2, 64'hA008); tick();
    drive_wb(0, 0); drive_wb(1, 1); drive_wb(2, 2); tick();
    tick();
    tick();
    check("skip_cleared_on_enq", 64'(bus.cmt_skip[0]), 64'd0);
    drive_wb(0, 3); tick();
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
